// File: rtl/systolic_feed_ctrl_if.sv
// Host/array handshake bundle for the systolic feed controller.
// The host drives operands; the controller returns skewed lanes and status.
interface systolic_feed_ctrl_if #(
  parameter int N          = 3,
  parameter int DATA_WIDTH = 8,
  parameter int SHIFT_LEN  = 2*N-1
) ();
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic                                     in_valid;
  logic                                     in_ready;
  logic [0:N-1][0:N-1][DATA_WIDTH-1:0]      mat_a;
  logic [0:N-1][0:N-1][DATA_WIDTH-1:0]      mat_b;
  logic [0:N-1][0:N-1]                      mask_a;
  logic [0:N-1][0:N-1]                      mask_b;
  logic                                     abort;
  logic [0:SHIFT_LEN-1][DATA_WIDTH-1:0]     a_lane;
  logic [0:SHIFT_LEN-1][DATA_WIDTH-1:0]     b_lane;
  logic [0:SHIFT_LEN-1]                     a_lane_vld;
  logic [0:SHIFT_LEN-1]                     b_lane_vld;
  logic [SW-1:0]                            step;
  logic                                     busy;
  logic                                     done;

  modport master (
    output in_valid, mat_a, mat_b, mask_a, mask_b, abort,
    input  in_ready, a_lane, b_lane, a_lane_vld, b_lane_vld,
    input  step, busy, done
  );

  modport slave (
    input  in_valid, mat_a, mat_b, mask_a, mask_b, abort,
    output in_ready, a_lane, b_lane, a_lane_vld, b_lane_vld,
    output step, busy, done
  );
endinterface

// File: rtl/systolic_feed_ctrl.sv
// Feeds an NxN operand pair into a systolic array as skewed lanes,
// then flushes the array and pulses done.
module systolic_feed_ctrl #(
  parameter int N            = 3,
  parameter int DATA_WIDTH   = 8,
  parameter int SHIFT_LEN    = 2*N-1,
  parameter int DRAIN_CYCLES = 2*N-1
) (
  input  logic                clk,
  input  logic                rst_n,
  systolic_feed_ctrl_if.slave bus
);
  localparam int SW   = (N > 1) ? $clog2(N) : 1;
  localparam int MAXC = (N > DRAIN_CYCLES) ? N : DRAIN_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef logic [0:N-1][0:N-1][DATA_WIDTH-1:0]  mat_t;
  typedef logic [0:N-1][0:N-1]                  msk_t;
  typedef logic [0:SHIFT_LEN-1][DATA_WIDTH-1:0] lane_t;
  typedef logic [0:SHIFT_LEN-1]                 vld_t;
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t        state_q;
  mat_t          a_q, b_q;
  msk_t          ma_q, mb_q;
  logic [SW-1:0] step_q;
  logic [CW-1:0] cnt_q;
  lane_t         a_lane_q, b_lane_q;
  vld_t          a_vld_q, b_vld_q;
  logic          busy_q, done_q;

  mat_t  src_a, src_b;
  msk_t  src_ma, src_mb;
  int    nk;
  lane_t a_nxt, b_nxt;
  vld_t  av_nxt, bv_nxt;

  // Step 0 is loaded straight from the bus on the accept edge.
  always_comb begin
    src_a  = a_q;
    src_b  = b_q;
    src_ma = ma_q;
    src_mb = mb_q;
    nk     = int'(step_q) + 1;
    if (state_q == IDLE) begin
      src_a  = bus.mat_a;
      src_b  = bus.mat_b;
      src_ma = bus.mask_a;
      src_mb = bus.mask_b;
      nk     = 0;
    end
    a_nxt  = '0;
    b_nxt  = '0;
    av_nxt = '0;
    bv_nxt = '0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (k == nk && k + i < SHIFT_LEN) begin
          a_nxt[k+i]  = src_a[k][i];
          av_nxt[k+i] = src_ma[k][i];
          b_nxt[k+i]  = src_b[i][k];
          bv_nxt[k+i] = src_mb[i][k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      ma_q     <= '0;
      mb_q     <= '0;
      step_q   <= '0;
      cnt_q    <= '0;
      a_lane_q <= '0;
      b_lane_q <= '0;
      a_vld_q  <= '0;
      b_vld_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      a_lane_q <= '0;
      b_lane_q <= '0;
      a_vld_q  <= '0;
      b_vld_q  <= '0;
      step_q   <= '0;
      done_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q      <= bus.mat_a;
            b_q      <= bus.mat_b;
            ma_q     <= bus.mask_a;
            mb_q     <= bus.mask_b;
            state_q  <= FEED;
            busy_q   <= 1'b1;
            a_lane_q <= a_nxt;
            b_lane_q <= b_nxt;
            a_vld_q  <= av_nxt;
            b_vld_q  <= bv_nxt;
          end
        end
        FEED: begin
          if (bus.abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (step_q == SW'(N-1)) begin
            state_q <= DRAIN;
            cnt_q   <= '0;
          end else begin
            step_q   <= step_q + 1'b1;
            a_lane_q <= a_nxt;
            b_lane_q <= b_nxt;
            a_vld_q  <= av_nxt;
            b_vld_q  <= bv_nxt;
          end
        end
        DRAIN: begin
          if (bus.abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == CW'(DRAIN_CYCLES-1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = (state_q == IDLE) && rst_n;
  assign bus.a_lane     = a_lane_q;
  assign bus.b_lane     = b_lane_q;
  assign bus.a_lane_vld = a_vld_q;
  assign bus.b_lane_vld = b_vld_q;
  assign bus.step       = step_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Scoreboard bench for systolic_feed_ctrl (N=3): per-cycle expected
// outputs are queued by the stimulus and checked by a negedge monitor.
module tb_systolic_feed_ctrl;
  localparam int N  = 3;
  localparam int DW = 8;
  localparam int SL = 2*N-1;
  localparam int DC = 2*N-1;

  typedef logic [0:N-1][0:N-1][DW-1:0] mat_t;
  typedef logic [0:N-1][0:N-1]         msk_t;
  typedef logic [0:SL-1][DW-1:0]       lane_t;
  typedef logic [0:SL-1]               vld_t;

  typedef struct packed {
    lane_t      a;
    lane_t      b;
    vld_t       av;
    vld_t       bv;
    logic [1:0] step;
    logic       busy;
    logic       done;
    logic       rdy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  systolic_feed_ctrl_if #(.N(N), .DATA_WIDTH(DW), .SHIFT_LEN(SL)) bus ();

  systolic_feed_ctrl #(
    .N(N), .DATA_WIDTH(DW), .SHIFT_LEN(SL), .DRAIN_CYCLES(DC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  exp_t  q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc   = 0;
  lane_t lit_a[N];
  lane_t lit_b[N];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e, g;
    if (q.size() != 0) begin
      e = q.pop_front();
      g.a    = bus.a_lane;
      g.b    = bus.b_lane;
      g.av   = bus.a_lane_vld;
      g.bv   = bus.b_lane_vld;
      g.step = bus.step;
      g.busy = bus.busy;
      g.done = bus.done;
      g.rdy  = bus.in_ready;
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL cyc%0d outputs: got a=%h b=%h av=%b bv=%b st=%0d bsy=%b dn=%b rdy=%b want a=%h b=%h av=%b bv=%b st=%0d bsy=%b dn=%b rdy=%b",
          cyc, g.a, g.b, g.av, g.bv, g.step, g.busy, g.done, g.rdy,
          e.a, e.b, e.av, e.bv, e.step, e.busy, e.done, e.rdy);
      end
    end
  end

  function automatic exp_t idle_e();
    exp_t e = '0;
    e.rdy = 1'b1;
    return e;
  endfunction

  function automatic exp_t feed_e(int k, mat_t a, mat_t b,
                                  msk_t ma, msk_t mb, bit hand);
    exp_t e = '0;
    e.busy = 1'b1;
    e.step = 2'(k);
    for (int i = 0; i < N; i++) begin
      e.a[k+i]  = a[k][i];
      e.av[k+i] = ma[k][i];
      e.b[k+i]  = b[i][k];
      e.bv[k+i] = mb[i][k];
    end
    if (hand) begin
      e.a = lit_a[k];
      e.b = lit_b[k];
    end
    return e;
  endfunction

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      q.push_back(idle_e());
      next();
    end
  endtask

  // Called one tick after a rising edge while the DUT is idle.
  // ev_at: cycle (relative to accept cycle) for abort/reset; -1 none.
  task automatic run_job(input mat_t a, input mat_t b,
                         input msk_t ma, input msk_t mb,
                         input int ev_at, input bit use_rst,
                         input bit keep, input bit hand);
    int   last;
    exp_t e;
    last = (ev_at >= 1) ? ev_at : N + DC + 1;
    for (int c = 0; c <= last; c++) begin
      if (c == 0) e = idle_e();
      else if (c <= N) e = feed_e(c-1, a, b, ma, mb, hand);
      else begin
        e = '0;
        e.busy = 1'b1;
        e.done = (c == N + DC + 1);
      end
      q.push_back(e);
    end
    bus.mat_a    = a;
    bus.mat_b    = b;
    bus.mask_a   = ma;
    bus.mask_b   = mb;
    bus.in_valid = 1'b1;
    bus.abort    = (ev_at == 0);
    for (int c = 0; c <= last; c++) begin
      if (c == 1) begin
        bus.in_valid = keep;
        bus.abort    = 1'b0;
        bus.mat_a    = ~a;
        bus.mask_a   = '0;
      end
      if (ev_at >= 1 && c == ev_at) begin
        if (use_rst) rst_n = 1'b0;
        else bus.abort = 1'b1;
      end
      next();
    end
    bus.abort = 1'b0;
    rst_n     = 1'b1;
  endtask

  mat_t a0, b0, a1, b1;
  msk_t m1, mx;

  initial begin
    lit_a[0] = {8'd1, 8'd2, 8'd3, 8'd0, 8'd0};
    lit_a[1] = {8'd0, 8'd4, 8'd5, 8'd6, 8'd0};
    lit_a[2] = {8'd0, 8'd0, 8'd7, 8'd8, 8'd9};
    lit_b[0] = {8'd10, 8'd13, 8'd16, 8'd0, 8'd0};
    lit_b[1] = {8'd0, 8'd11, 8'd14, 8'd17, 8'd0};
    lit_b[2] = {8'd0, 8'd0, 8'd12, 8'd15, 8'd18};
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        a0[r][c] = 8'(r*N + c + 1);
        b0[r][c] = 8'(r*N + c + 10);
        a1[r][c] = 8'(8'hA0 + r*16 + c);
        b1[r][c] = 8'(8'h50 + c*16 + r);
      end
    m1 = '1;
    mx = '1;
    mx[1][2] = 1'b0;

    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.abort    = 1'b0;
    bus.mat_a    = '0;
    bus.mat_b    = '0;
    bus.mask_a   = '0;
    bus.mask_b   = '0;
    next();
    q.push_back(exp_t'('0));
    next();
    rst_n = 1'b1;
    idle(2);

    run_job(a0, b0, m1, m1, -1, 1'b0, 1'b0, 1'b1);
    idle(2);
    run_job(a0, b0, mx, m1, -1, 1'b0, 1'b0, 1'b1);
    idle(1);
    run_job(a1, b1, m1, mx, 2, 1'b0, 1'b0, 1'b0);
    idle(3);
    run_job(a1, b0, mx, mx, 0, 1'b0, 1'b0, 1'b0);
    idle(1);
    run_job(a0, b0, m1, m1, -1, 1'b0, 1'b1, 1'b1);
    run_job(a1, b1, mx, m1, -1, 1'b0, 1'b0, 1'b0);
    idle(1);
    run_job(a0, b1, m1, m1, 6, 1'b0, 1'b0, 1'b0);
    idle(3);
    run_job(a1, b1, m1, m1, 2, 1'b1, 1'b0, 1'b0);
    idle(3);
    run_job(a1, b1, m1, mx, -1, 1'b0, 1'b0, 1'b0);
    idle(2);

    repeat (5) next();
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
